// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling (16x) UART receiver. Synchronises the async rx
//            line, finds mid-bit sample points from the bd_tick strobe and
//            delivers each LSB-first frame on dout with a one-cycle done
//            strobe and a stop-bit framing-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DBIT    = 8,   // data bits per frame (1..16)
    parameter int SB_TICK = 16   // bd_tick count spanning the stop bit
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            bd_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    // Tick counter must reach SB_TICK-1 as well as the 15 used per data bit.
    localparam int c_SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    localparam logic [c_SW-1:0] c_S_MID  = c_SW'(7);
    localparam logic [c_SW-1:0] c_S_BIT  = c_SW'(15);
    localparam logic [c_SW-1:0] c_S_STOP = c_SW'(SB_TICK - 1);
    localparam logic [c_SW-1:0] c_S_ONE  = c_SW'(1);
    localparam logic [c_NW-1:0] c_N_LAST = c_NW'(DBIT - 1);
    localparam logic [c_NW-1:0] c_N_ONE  = c_NW'(1);

    logic [1:0]      r_sync;
    logic            w_rx_s;

    logic [1:0]      r_state,  w_state_next;
    logic [c_SW-1:0] r_s_cnt,  w_s_cnt_next;
    logic [c_NW-1:0] r_n_cnt,  w_n_cnt_next;
    logic [DBIT-1:0] r_b,      w_b_next;
    logic [DBIT-1:0] w_b_shift;
    logic [DBIT-1:0] r_dout,   w_dout_next;
    logic            r_ferr,   w_ferr_next;
    logic            r_done,   w_done_next;

    assign w_rx_s       = r_sync[1];
    assign dout         = r_dout;
    assign frame_err    = r_ferr;
    assign rx_done_tick = r_done;

    // New bit enters at the MSB so the first (LSB) bit ends up at bit 0.
    if (DBIT > 1) begin : g_shift_multi
        assign w_b_shift = {w_rx_s, r_b[DBIT-1:1]};
    end else begin : g_shift_single
        assign w_b_shift = w_rx_s;
    end

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s_cnt <= w_s_cnt_next;
            r_n_cnt <= w_n_cnt_next;
            r_b     <= w_b_next;
            r_dout  <= w_dout_next;
            r_ferr  <= w_ferr_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; everything except IDLE->START advances only on bd_tick.
    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_n_cnt_next = r_n_cnt;
        w_b_next     = r_b;
        w_dout_next  = r_dout;
        w_ferr_next  = r_ferr;
        w_done_next  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = c_START;
                    w_s_cnt_next = '0;
                end
            end
            c_START: begin
                if (bd_tick) begin
                    if (r_s_cnt == c_S_MID) begin
                        if (!w_rx_s) begin
                            w_state_next = c_DATA;
                            w_s_cnt_next = '0;
                            w_n_cnt_next = '0;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            w_state_next = c_IDLE;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + c_S_ONE;
                    end
                end
            end
            c_DATA: begin
                if (bd_tick) begin
                    if (r_s_cnt == c_S_BIT) begin
                        w_s_cnt_next = '0;
                        w_b_next     = w_b_shift;
                        if (r_n_cnt == c_N_LAST) begin
                            w_state_next = c_STOP;
                        end else begin
                            w_n_cnt_next = r_n_cnt + c_N_ONE;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + c_S_ONE;
                    end
                end
            end
            c_STOP: begin
                if (bd_tick) begin
                    if (r_s_cnt == c_S_STOP) begin
                        // Leave mid stop bit so an immediate next start is caught.
                        w_dout_next  = r_b;
                        w_ferr_next  = ~w_rx_s;
                        w_done_next  = 1'b1;
                        w_state_next = c_IDLE;
                    end else begin
                        w_s_cnt_next = r_s_cnt + c_S_ONE;
                    end
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that sits directly downstream of the baud-rate generator. It consumes the generator's `bd_tick` strobe (16 ticks per bit period), synchronises the asynchronous `rx` line, and recovers 8N1-style frames (LSB first). Each received byte is presented on `dout` with a one-cycle `rx_done_tick` strobe for the FIFO/interface logic that follows.

## Interface
- `DBIT`, 8: data bits per frame (1..16).
- `SB_TICK`, 16: `bd_tick` count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: serial line, asynchronous, idle high.
- `bd_tick` input 1: one-`clk`-wide strobe at 16x the baud rate, from the baud-rate generator.
- `dout` output DBIT: last received data word.
- `rx_done_tick` output 1: one-cycle pulse when `dout` is updated.
- `frame_err` output 1: stop-bit status of the last frame (1 = stop sampled low).

## Operation
- `rx` passes through a 2-flop synchroniser reset to 1. All decisions use the synchronised value `rx_s`.
- Registers:
  - `state` ∈ {IDLE, START, DATA, STOP}
  - `s_cnt` (4 bits, or wide enough for `SB_TICK-1`)
  - `n_cnt` (ceil log2 DBIT)
  - shift register `b` (DBIT)
- IDLE: if `rx_s`==0, go to START and set `s_cnt`<=0. This does not wait for a tick.
- START: on `bd_tick`:
  - If `s_cnt`==7 (mid start bit) and `rx_s`==0: go to DATA, `s_cnt`<=0, `n_cnt`<=0.
  - If `s_cnt`==7 and `rx_s`==1: treat as a glitch and return to IDLE with no output.
  - Otherwise `s_cnt`++.
- DATA: on `bd_tick`:
  - If `s_cnt`==15: `s_cnt`<=0 and `b`<={`rx_s`, `b[DBIT-1:1]`} (LSB first). If `n_cnt`==DBIT-1, go to STOP; otherwise `n_cnt`++.
  - Otherwise `s_cnt`++.
- STOP: on `bd_tick`:
  - If `s_cnt`==SB_TICK-1: `dout`<=`b`, `frame_err`<=~`rx_s`, `rx_done_tick`<=1, go to IDLE.
  - Otherwise `s_cnt`++.
  - The return to IDLE happens mid stop bit, so the next start edge is caught.
- Without `bd_tick`, counters and state hold. IDLE→START is the only tick-independent transition.
- A frame with a framing error is still delivered: `dout` is valid and `rx_done_tick` pulses.
- `dout` and `frame_err` hold until the next completed frame.

## Timing
- Reset values: `state`=IDLE, `s_cnt`=0, `n_cnt`=0, `b`=0, `dout`=0, `rx_done_tick`=0, `frame_err`=0, synchroniser flops=1.
- `rst` asserted mid-frame aborts the frame on the next edge. No `rx_done_tick` is produced for it, and `dout`/`frame_err` clear to 0.
- Synchroniser latency is 2 `clk` cycles from `rx` to `rx_s`.
- All outputs are registered. `rx_done_tick` is high for exactly the one `clk` cycle after the edge that samples the final qualifying `bd_tick` in STOP.
- From the first IDLE→START edge, frame completion takes 8 + 16·DBIT + SB_TICK `bd_tick` strobes. That is 152 for the defaults.
- Bit sampling falls at tick 7 of the start bit, then every 16 ticks (mid-bit).
- Back-to-back frames with no idle gap are received without loss.

## Test plan
- Bench setup: baud-rate generator with N=10, so `bd_tick` fires every 10 `clk` cycles and one bit = 160 `clk`. Reset is held for 2 cycles.
- Send 0xA5 with a valid stop bit → exactly one `rx_done_tick`, `dout`=0xA5, `frame_err`=0. Done occurs 152 ticks (±1 tick) after the falling edge.
- Drive `rx` low for 3 bit-ticks (30 `clk`), then high → no `rx_done_tick`. FSM is back in IDLE. A following 0x5A frame is received correctly.
- Send 0x3C with the stop bit driven 0 → `rx_done_tick` pulses, `dout`=0x3C, `frame_err`=1. The next good frame 0x0F clears `frame_err` to 0.
- Send 0x00 then 0xFF back-to-back with no idle gap → two done pulses 160 ticks apart, `dout`=0x00 then 0xFF, `frame_err`=0 both times.
- Assert `rst` for 1 cycle during the 4th data bit of 0x81 → no done pulse, and all outputs are 0 the next cycle. A fresh 0x81 frame is then received with `dout`=0x81.
